// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave byte layer: word width, SPI mode and
// the idle pin levels the synchronisers reset to.
package spi_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int SPI_MODE           = 0;

  // Idle SCLK level follows CPOL, which is bit 1 of the SPI mode number.
  localparam logic SCLK_IDLE = (SPI_MODE >= 2);
  localparam logic CSN_IDLE  = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// N-stage flip-flop synchroniser for one asynchronous pin, resetting to the
// pin's idle level so no spurious edge is seen when reset releases.
module spi_sync #(
  parameter int   Stages   = 2,
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= {Stages{ResetVal}};
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value;
      // blocking here would collapse the chain into a single flop.
      pipe <= {pipe[Stages-2:0], d};
    end
  end

  assign q = pipe[Stages-1];

endmodule : spi_sync

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 slave byte layer: synchronises the pins, deserialises MOSI into
// bytes and serialises the holding register onto MISO, MSB first.
module spi_byte_shifter
  import spi_pkg::*;
#(
  parameter int DataWidth  = DATA_WIDTH_DEFAULT,
  parameter int SyncStages = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 csN,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 misoEn,
  output logic                 chipSelect,
  output logic                 byteRead,
  output logic [DataWidth-1:0] rxByte,
  input  logic [DataWidth-1:0] txByte,
  input  logic                 loadTx
);

  localparam int                  CntWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntWidth-1:0] LastBit  = CntWidth'(DataWidth - 1);

  logic                 sclkSync, csSync, mosiSync;
  logic                 sclkPrev, csPrev;
  logic                 rise, fall;
  logic [CntWidth-1:0]  bitCnt;
  logic [DataWidth-2:0] rxShift;
  logic [DataWidth-1:0] rxNext;
  logic [DataWidth-2:0] txShift;
  logic [DataWidth-1:0] holding;
  logic                 boundary;
  logic                 byteReadQ;

  spi_sync #(.Stages(SyncStages), .ResetVal(SCLK_IDLE)) uSclkSync (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclkSync)
  );

  spi_sync #(.Stages(SyncStages), .ResetVal(CSN_IDLE)) uCsSync (
    .clk(clk), .rst_n(rst_n), .d(csN), .q(csSync)
  );

  spi_sync #(.Stages(SyncStages), .ResetVal(MOSI_IDLE)) uMosiSync (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosiSync)
  );

  assign chipSelect = csSync;
  assign rxNext     = {rxShift, mosiSync};

  // Gated so a deselect clears the flag in the same cycle chipSelect rises.
  assign byteRead = byteReadQ & ~csSync;

  // Registered edge pulses keep pin-to-pulse latency at SyncStages+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclkPrev <= SCLK_IDLE;
      csPrev   <= CSN_IDLE;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sclkPrev <= sclkSync;
      csPrev   <= csSync;
      rise     <= sclkSync & ~sclkPrev;
      fall     <= ~sclkSync & sclkPrev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift registers are reset along with the control state so
      // every output is defined the moment rst_n asserts.
      bitCnt    <= '0;
      rxShift   <= '0;
      rxByte    <= '0;
      txShift   <= '0;
      holding   <= '0;
      boundary  <= 1'b0;
      byteReadQ <= 1'b0;
      miso      <= 1'b0;
      misoEn    <= 1'b0;
    end else begin
      if (loadTx) begin
        holding <= txByte;
      end

      if (csSync) begin
        bitCnt    <= '0;
        byteReadQ <= 1'b0;
        boundary  <= 1'b0;
        misoEn    <= 1'b0;
        miso      <= 1'b0;
      end else if (csPrev) begin
        // Select edge: first transmit bit must be on the pin before the first rise.
        txShift <= holding[DataWidth-2:0];
        miso    <= holding[DataWidth-1];
        misoEn  <= 1'b1;
      end else begin
        if (rise) begin
          rxShift <= rxNext[DataWidth-2:0];
          if (bitCnt == LastBit) begin
            bitCnt    <= '0;
            rxByte    <= rxNext;
            byteReadQ <= 1'b1;
            boundary  <= 1'b1;
          end else begin
            bitCnt <= bitCnt + CntWidth'(1);
            if (bitCnt == '0) begin
              byteReadQ <= 1'b0;
            end
          end
        end

        if (fall) begin
          if (boundary) begin
            txShift  <= holding[DataWidth-2:0];
            miso     <= holding[DataWidth-1];
            boundary <= 1'b0;
          end else begin
            txShift <= txShift << 1;
            miso    <= txShift[DataWidth-2];
          end
        end
      end
    end
  end

endmodule : spi_byte_shifter

// File: tb/tb_spi_byte_shifter.sv
// Self-checking bench for spi_byte_shifter: a host model drives the SPI pins,
// expected RX and MISO bytes go through scoreboard queues.
module tb_spi_byte_shifter;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       csN;
  logic       mosi;
  logic       miso;
  logic       misoEn;
  logic       chipSelect;
  logic       byteRead;
  logic [7:0] rxByte;
  logic [7:0] txByte;
  logic       loadTx;

  int passCnt  = 0;
  int checkCnt = 0;

  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];
  logic [7:0] lastRx = 8'h00;
  logic       brPrev = 1'b0;

  spi_byte_shifter dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .csN(csN), .mosi(mosi),
    .miso(miso), .misoEn(misoEn), .chipSelect(chipSelect), .byteRead(byteRead),
    .rxByte(rxByte), .txByte(txByte), .loadTx(loadTx)
  );

  always #5 clk = ~clk;

  // RX scoreboard: every rising byteRead must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && byteRead === 1'b1 && brPrev !== 1'b1) begin
      checkCnt++;
      if (rxQ.size() == 0) begin
        $display("FAIL rx_unexpected: byteRead rose with rxByte=%h, none expected", rxByte);
      end else begin
        logic [7:0] exp;
        exp = rxQ.pop_front();
        if (rxByte !== exp) $display("FAIL rx_byte: got %h expected %h", rxByte, exp);
        else passCnt++;
      end
    end
    brPrev <= byteRead;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    checkCnt++;
    if (got !== exp) $display("FAIL %s: got %b expected %b", name, got, exp);
    else passCnt++;
  endtask

  task automatic selectSlave();
    csN = 1'b0;
    waitClk(HALF);
  endtask

  task automatic deselectSlave();
    csN = 1'b1;
    waitClk(HALF);
  endtask

  task automatic loadHolding(input logic [7:0] val, input int cycles);
    txByte = val;
    loadTx = 1'b1;
    waitClk(cycles);
    loadTx = 1'b0;
  endtask

  // One full host byte: MOSI driven MSB first, MISO sampled just before each rise.
  task automatic xferByte(input logic [7:0] rxVal, input bit chkLat,
                          input bit doLoad, input logic [7:0] loadVal);
    logic [7:0] seen;
    logic [7:0] expTx;
    rxQ.push_back(rxVal);
    lastRx = rxVal;
    for (int i = 7; i >= 0; i--) begin
      mosi = rxVal[i];
      waitClk(HALF);
      seen[i] = miso;
      sclk = 1'b1;
      if (chkLat && i == 7) begin
        waitClk(4);
        checkBit("byteRead_after_first_rise", byteRead, 1'b0);
        waitClk(HALF - 4);
      end else if (chkLat && i == 0) begin
        waitClk(3);
        checkBit("byteRead_latency_early", byteRead, 1'b0);
        waitClk(1);
        checkBit("byteRead_latency_exact", byteRead, 1'b1);
        checkCnt++;
        if (rxByte !== rxVal) $display("FAIL rxByte_latency: got %h expected %h", rxByte, rxVal);
        else passCnt++;
        waitClk(HALF - 4);
      end else if (doLoad && i == 0) begin
        waitClk(5);
        loadHolding(loadVal, 2);
        waitClk(HALF - 7);
      end else begin
        waitClk(HALF);
      end
      sclk = 1'b0;
    end
    checkCnt++;
    if (txQ.size() == 0) begin
      $display("FAIL miso_unexpected: MISO byte %h with nothing expected", seen);
    end else begin
      expTx = txQ.pop_front();
      if (seen !== expTx) $display("FAIL miso_byte: got %h expected %h", seen, expTx);
      else passCnt++;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sclk   = 1'b0;
    csN    = 1'b1;
    mosi   = 1'b0;
    txByte = 8'h00;
    loadTx = 1'b0;
    waitClk(3);
    checkBit("reset_miso", miso, 1'b0);
    checkBit("reset_misoEn", misoEn, 1'b0);
    checkBit("reset_chipSelect", chipSelect, 1'b1);
    checkBit("reset_byteRead", byteRead, 1'b0);
    checkCnt++;
    if (rxByte !== 8'h00) $display("FAIL reset_rxByte: got %h expected 00", rxByte);
    else passCnt++;
    rst_n = 1'b1;
    waitClk(5);
  endtask

  task automatic test_single_receive();
    selectSlave();
    txQ.push_back(8'h00);
    xferByte(8'hA5, 1'b1, 1'b0, 8'h00);
    checkBit("byteRead_held_low_phase", byteRead, 1'b1);
    txQ.push_back(8'h00);
    xferByte(8'h5A, 1'b1, 1'b0, 8'h00);
    deselectSlave();
  endtask

  task automatic test_transmit();
    loadHolding(8'h3C, 3);
    waitClk(2);
    selectSlave();
    checkBit("misoEn_selected", misoEn, 1'b1);
    txQ.push_back(8'h3C);
    xferByte(8'hC3, 1'b0, 1'b0, 8'h00);
    deselectSlave();
    checkBit("misoEn_deselected", misoEn, 1'b0);
  endtask

  task automatic test_back_to_back();
    selectSlave();
    txQ.push_back(8'h3C);
    xferByte(8'h12, 1'b0, 1'b1, 8'h81);
    txQ.push_back(8'h81);
    xferByte(8'h34, 1'b0, 1'b0, 8'h00);
    csN = 1'b1;
    waitClk(1);
    checkBit("deselect_cs_lag", chipSelect, 1'b0);
    checkBit("deselect_byteRead_before", byteRead, 1'b1);
    waitClk(1);
    checkBit("deselect_chipSelect", chipSelect, 1'b1);
    checkBit("deselect_byteRead_cleared", byteRead, 1'b0);
    waitClk(1);
    checkBit("deselect_misoEn", misoEn, 1'b0);
    checkBit("deselect_miso", miso, 1'b0);
    waitClk(HALF);
  endtask

  task automatic test_abort();
    logic [7:0] prevRx;
    prevRx = lastRx;
    selectSlave();
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(HALF);
      sclk = 1'b0;
    end
    deselectSlave();
    checkBit("abort_byteRead", byteRead, 1'b0);
    checkCnt++;
    if (rxByte !== prevRx) $display("FAIL abort_rxByte: got %h expected %h", rxByte, prevRx);
    else passCnt++;
    selectSlave();
    txQ.push_back(8'h81);
    xferByte(8'h0F, 1'b0, 1'b0, 8'h00);
    deselectSlave();
  endtask

  task automatic test_collision();
    loadHolding(8'hAA, 1);
    waitClk(2);
    selectSlave();
    txQ.push_back(8'hAA);
    xferByte(8'h99, 1'b0, 1'b0, 8'h00);
    // The boundary fall pulse is live during the third cycle after the pin edge.
    waitClk(3);
    loadHolding(8'h55, 1);
    txQ.push_back(8'hAA);
    xferByte(8'h66, 1'b0, 1'b0, 8'h00);
    txQ.push_back(8'h55);
    xferByte(8'h77, 1'b0, 1'b0, 8'h00);
    deselectSlave();
  endtask

  task automatic test_reset_mid_byte();
    loadHolding(8'hC0, 1);
    waitClk(2);
    selectSlave();
    mosi = 1'b1;
    waitClk(HALF);
    sclk = 1'b1;
    waitClk(5);
    checkBit("premid_miso", miso, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkBit("midreset_miso", miso, 1'b0);
    checkBit("midreset_misoEn", misoEn, 1'b0);
    checkBit("midreset_chipSelect", chipSelect, 1'b1);
    checkBit("midreset_byteRead", byteRead, 1'b0);
    checkCnt++;
    if (rxByte !== 8'h00) $display("FAIL midreset_rxByte: got %h expected 00", rxByte);
    else passCnt++;
    waitClk(2);
    rst_n = 1'b1;
    waitClk(HALF);
    checkBit("postreset_misoEn", misoEn, 1'b1);
    checkBit("postreset_holding_msb", miso, 1'b0);
    sclk = 1'b0;
    csN  = 1'b1;
    waitClk(HALF);
  endtask

  initial begin
    test_reset();
    test_single_receive();
    test_transmit();
    test_back_to_back();
    test_abort();
    test_collision();
    test_reset_mid_byte();
    checkCnt++;
    if (rxQ.size() != 0 || txQ.size() != 0)
      $display("FAIL scoreboard_drain: rx left %0d tx left %0d expected 0 0", rxQ.size(), txQ.size());
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule : tb_spi_byte_shifter
